// File: rtl/core101_pkg.sv
// Shared encodings for the core101 control path: opcodes, FSM states,
// instruction classes and PC mux select codes.
package core101_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [1:0] PC_SEL_PLUS4  = 2'b00;
    localparam logic [1:0] PC_SEL_OFFSET = 2'b01;
    localparam logic [1:0] PC_SEL_NEW    = 2'b10;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEMORY    = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_HALT      = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        CLS_NONE   = 4'd0,
        CLS_LOAD   = 4'd1,
        CLS_STORE  = 4'd2,
        CLS_OPIMM  = 4'd3,
        CLS_OP     = 4'd4,
        CLS_LUI    = 4'd5,
        CLS_AUIPC  = 4'd6,
        CLS_JAL    = 4'd7,
        CLS_JALR   = 4'd8,
        CLS_BRANCH = 4'd9
    } class_e;

    // Classes whose second ALU operand comes from the immediate generator.
    function automatic logic class_uses_imm(input class_e cls);
        case (cls)
            CLS_OPIMM, CLS_LOAD, CLS_STORE,
            CLS_LUI, CLS_AUIPC, CLS_JALR: return 1'b1;
            default:                      return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/opcode_decoder.sv
// Combinational opcode classifier: instruction class, immediate operand
// select and illegal-opcode flag.
module opcode_decoder
    import core101_pkg::*;
(
    input  logic [6:0] opcode_i,
    output class_e     op_class_o,
    output logic       imm_sel_o,
    output logic       illegal_o
);

    // Map the raw opcode onto a class; anything unlisted is illegal.
    always_comb begin
        op_class_o = CLS_NONE;
        illegal_o  = 1'b0;
        case (opcode_i)
            OPC_LOAD:   op_class_o = CLS_LOAD;
            OPC_STORE:  op_class_o = CLS_STORE;
            OPC_OPIMM:  op_class_o = CLS_OPIMM;
            OPC_OP:     op_class_o = CLS_OP;
            OPC_LUI:    op_class_o = CLS_LUI;
            OPC_AUIPC:  op_class_o = CLS_AUIPC;
            OPC_JAL:    op_class_o = CLS_JAL;
            OPC_JALR:   op_class_o = CLS_JALR;
            OPC_BRANCH: op_class_o = CLS_BRANCH;
            default:    illegal_o  = 1'b1;
        endcase
    end

    assign imm_sel_o = class_uses_imm(op_class_o);

endmodule

// File: rtl/control_unit.sv
// Multi-cycle control FSM (FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK/HALT) with
// memory-ready timeout. Define CONTROL_UNIT_RETIRE_CNT_EN for a retire counter.
module control_unit
    import core101_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
)
(
    input  logic        control_unit_clock_in,
    input  logic        control_unit_reset_in,
    input  logic [6:0]  control_unit_opcode_in,
    input  logic        control_unit_ins_mem_ready_in,
    input  logic        control_unit_data_mem_ready_in,
    input  logic        control_unit_branch_taken_in,
    output logic        control_unit_pc_set_out,
    output logic        control_unit_ir_set_out,
    output logic [1:0]  control_unit_pc_mux_sel_out,
    output logic        control_unit_imm_mux_sel_out,
    output logic        control_unit_ins_mem_req_out,
    output logic        control_unit_data_mem_req_out,
    output logic        control_unit_data_mem_we_out,
    output logic        control_unit_gpr_set_rd_out,
    output logic        control_unit_illegal_out,
    output logic        control_unit_fault_out,
    output logic [2:0]  control_unit_state_out
`ifdef CONTROL_UNIT_RETIRE_CNT_EN
    ,
    output logic [31:0] control_unit_retired_count_out
`endif
);

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

    state_e     state_q,   state_d;
    class_e     class_q,   class_d;
    logic [7:0] wait_q,    wait_d;
    logic       illegal_q, illegal_d;
    logic       fault_q,   fault_d;

    class_e     dec_class_s;
    logic       dec_imm_s;
    logic       dec_illegal_s;
    logic [7:0] wait_inc_s;
    logic       timeout_hit_s;

    logic       pc_set_s;
    logic       ir_set_s;
    logic [1:0] pc_sel_s;
    logic       imm_sel_s;
    logic       ins_req_s;
    logic       data_req_s;
    logic       data_we_s;
    logic       gpr_set_s;

    opcode_decoder u_opcode_decoder (
        .opcode_i   (control_unit_opcode_in),
        .op_class_o (dec_class_s),
        .imm_sel_o  (dec_imm_s),
        .illegal_o  (dec_illegal_s)
    );

    // A timeout fires on the wait cycle that would bring the count up to the limit,
    // unless ready shows up in that very cycle.
    assign wait_inc_s    = wait_q + 8'd1;
    assign timeout_hit_s = (wait_inc_s == TIMEOUT_LIMIT);

    // Next-state, wait counter and strobe generation.
    always_comb begin
        state_d    = state_q;
        class_d    = class_q;
        wait_d     = 8'd0;
        illegal_d  = illegal_q;
        fault_d    = fault_q;
        pc_set_s   = 1'b0;
        ir_set_s   = 1'b0;
        pc_sel_s   = PC_SEL_PLUS4;
        imm_sel_s  = 1'b0;
        ins_req_s  = 1'b0;
        data_req_s = 1'b0;
        data_we_s  = 1'b0;
        gpr_set_s  = 1'b0;
        case (state_q)
            ST_FETCH: begin
                ins_req_s = 1'b1;
                if (control_unit_ins_mem_ready_in) begin
                    ir_set_s = 1'b1;
                    state_d  = ST_DECODE;
                end else if (timeout_hit_s) begin
                    fault_d = 1'b1;
                    state_d = ST_HALT;
                end else begin
                    wait_d = wait_inc_s;
                end
            end
            ST_DECODE: begin
                imm_sel_s = dec_imm_s;
                class_d   = dec_class_s;
                if (dec_illegal_s) begin
                    illegal_d = 1'b1;
                    state_d   = ST_HALT;
                end else begin
                    state_d = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                imm_sel_s = class_uses_imm(class_q);
                if (class_q == CLS_BRANCH) begin
                    pc_set_s = 1'b1;
                    pc_sel_s = control_unit_branch_taken_in ? PC_SEL_OFFSET : PC_SEL_PLUS4;
                    state_d  = ST_FETCH;
                end else if ((class_q == CLS_LOAD) || (class_q == CLS_STORE)) begin
                    state_d = ST_MEMORY;
                end else begin
                    state_d = ST_WRITEBACK;
                end
            end
            ST_MEMORY: begin
                imm_sel_s  = class_uses_imm(class_q);
                data_req_s = 1'b1;
                data_we_s  = (class_q == CLS_STORE);
                if (control_unit_data_mem_ready_in) begin
                    if (class_q == CLS_STORE) begin
                        pc_set_s = 1'b1;
                        state_d  = ST_FETCH;
                    end else begin
                        state_d = ST_WRITEBACK;
                    end
                end else if (timeout_hit_s) begin
                    fault_d = 1'b1;
                    state_d = ST_HALT;
                end else begin
                    wait_d = wait_inc_s;
                end
            end
            ST_WRITEBACK: begin
                imm_sel_s = class_uses_imm(class_q);
                gpr_set_s = 1'b1;
                pc_set_s  = 1'b1;
                case (class_q)
                    CLS_JAL:  pc_sel_s = PC_SEL_OFFSET;
                    CLS_JALR: pc_sel_s = PC_SEL_NEW;
                    default:  pc_sel_s = PC_SEL_PLUS4;
                endcase
                state_d = ST_FETCH;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // State, class, wait counter and sticky error flags.
    always_ff @(posedge control_unit_clock_in) begin
        if (control_unit_reset_in) begin
            state_q   <= ST_FETCH;
            class_q   <= CLS_NONE;
            wait_q    <= 8'd0;
            illegal_q <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            class_q   <= class_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            fault_q   <= fault_d;
        end
    end

    // Strobes are Mealy on the ready inputs; reset masks them so an aborted
    // instruction never commits in the reset cycle.
    assign control_unit_pc_set_out       = pc_set_s   & ~control_unit_reset_in;
    assign control_unit_ir_set_out       = ir_set_s   & ~control_unit_reset_in;
    assign control_unit_pc_mux_sel_out   = control_unit_reset_in ? PC_SEL_PLUS4 : pc_sel_s;
    assign control_unit_imm_mux_sel_out  = imm_sel_s  & ~control_unit_reset_in;
    assign control_unit_ins_mem_req_out  = ins_req_s  & ~control_unit_reset_in;
    assign control_unit_data_mem_req_out = data_req_s & ~control_unit_reset_in;
    assign control_unit_data_mem_we_out  = data_we_s  & ~control_unit_reset_in;
    assign control_unit_gpr_set_rd_out   = gpr_set_s  & ~control_unit_reset_in;
    assign control_unit_illegal_out      = illegal_q;
    assign control_unit_fault_out        = fault_q;
    assign control_unit_state_out        = state_q;

`ifdef CONTROL_UNIT_RETIRE_CNT_EN
    logic [31:0] retired_q;

    // Retired-instruction count, one per PC update, wrapping naturally.
    always_ff @(posedge control_unit_clock_in) begin
        if (control_unit_reset_in) begin
            retired_q <= 32'd0;
        end else if (pc_set_s) begin
            retired_q <= retired_q + 32'd1;
        end else begin
            retired_q <= retired_q;
        end
    end

    assign control_unit_retired_count_out = retired_q;
`endif

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: per-instruction expected traces are
// generated from the instruction-class rules and compared every cycle.
module tb_control_unit;

    localparam int TO        = 16;
    localparam int HALT_HOLD = 4;

    localparam logic [6:0] O_LOAD   = 7'b0000011;
    localparam logic [6:0] O_STORE  = 7'b0100011;
    localparam logic [6:0] O_OPIMM  = 7'b0010011;
    localparam logic [6:0] O_OP     = 7'b0110011;
    localparam logic [6:0] O_LUI    = 7'b0110111;
    localparam logic [6:0] O_AUIPC  = 7'b0010111;
    localparam logic [6:0] O_JAL    = 7'b1101111;
    localparam logic [6:0] O_JALR   = 7'b1100111;
    localparam logic [6:0] O_BRANCH = 7'b1100011;
    localparam logic [6:0] O_SYSTEM = 7'b1110011;

    localparam int K_ILL = 0, K_ALU = 1, K_JAL = 2, K_JALR = 3, K_BR = 4, K_LD = 5, K_ST = 6;

    typedef struct packed {
        logic [2:0] state;
        logic       ins_req;
        logic       ir_set;
        logic       pc_set;
        logic [1:0] pc_sel;
        logic       imm;
        logic       dreq;
        logic       dwe;
        logic       gpr;
        logic       illegal;
        logic       fault;
    } obs_t;

    typedef struct {
        logic       ins_rdy;
        logic       d_rdy;
        logic       taken;
        logic [6:0] opc;
        obs_t       exp;
    } step_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  opc;
    logic        ins_rdy, d_rdy, taken;
    logic        pc_set, ir_set, imm, ins_req, dreq, dwe, gpr, illegal, fault;
    logic [1:0]  pc_sel;
    logic [2:0]  state;
`ifdef CONTROL_UNIT_RETIRE_CNT_EN
    logic [31:0] retired;
`endif

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] exp_retired = 32'd0;
    step_t       trace[$];

    always #5 clk = ~clk;

    control_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .control_unit_clock_in          (clk),
        .control_unit_reset_in          (rst),
        .control_unit_opcode_in         (opc),
        .control_unit_ins_mem_ready_in  (ins_rdy),
        .control_unit_data_mem_ready_in (d_rdy),
        .control_unit_branch_taken_in   (taken),
        .control_unit_pc_set_out        (pc_set),
        .control_unit_ir_set_out        (ir_set),
        .control_unit_pc_mux_sel_out    (pc_sel),
        .control_unit_imm_mux_sel_out   (imm),
        .control_unit_ins_mem_req_out   (ins_req),
        .control_unit_data_mem_req_out  (dreq),
        .control_unit_data_mem_we_out   (dwe),
        .control_unit_gpr_set_rd_out    (gpr),
        .control_unit_illegal_out       (illegal),
        .control_unit_fault_out         (fault),
        .control_unit_state_out         (state)
`ifdef CONTROL_UNIT_RETIRE_CNT_EN
        ,
        .control_unit_retired_count_out (retired)
`endif
    );

    function automatic int kind_of(input logic [6:0] o);
        case (o)
            O_OP, O_OPIMM, O_LUI, O_AUIPC: return K_ALU;
            O_JAL:    return K_JAL;
            O_JALR:   return K_JALR;
            O_BRANCH: return K_BR;
            O_LOAD:   return K_LD;
            O_STORE:  return K_ST;
            default:  return K_ILL;
        endcase
    endfunction

    function automatic logic uses_imm(input logic [6:0] o);
        return (o == O_OPIMM) || (o == O_LOAD) || (o == O_STORE) ||
               (o == O_LUI) || (o == O_AUIPC) || (o == O_JALR);
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [6:0] r7();
        return 7'($urandom);
    endfunction

    function automatic obs_t sample_obs();
        obs_t o;
        o.state   = state;
        o.ins_req = ins_req;
        o.ir_set  = ir_set;
        o.pc_set  = pc_set;
        o.pc_sel  = pc_sel;
        o.imm     = imm;
        o.dreq    = dreq;
        o.dwe     = dwe;
        o.gpr     = gpr;
        o.illegal = illegal;
        o.fault   = fault;
        return o;
    endfunction

    task automatic push_step(input logic ir, input logic dr, input logic tk,
                             input logic [6:0] op, input obs_t e);
        step_t s;
        s.ins_rdy = ir;
        s.d_rdy   = dr;
        s.taken   = tk;
        s.opc     = op;
        s.exp     = e;
        trace.push_back(s);
    endtask

    task automatic push_halt(input logic il, input logic fl);
        obs_t e;
        for (int i = 0; i < HALT_HOLD; i++) begin
            e = '0;
            e.state   = 3'd5;
            e.illegal = il;
            e.fault   = fl;
            push_step(rb(), rb(), rb(), r7(), e);
        end
    endtask

    // Expected cycle sequence of one instruction: w1 / w2 are the number of
    // not-ready cycles seen before instruction / data ready arrives.
    task automatic build_trace(input logic [6:0] op, input logic tk, input int w1,
                               input int w2, output logic halted);
        obs_t e;
        int   k;
        logic im;
        k      = kind_of(op);
        im     = uses_imm(op);
        halted = 1'b0;
        for (int i = 0; i < w1 && i < TO; i++) begin
            e = '0; e.state = 3'd0; e.ins_req = 1'b1;
            push_step(1'b0, rb(), rb(), r7(), e);
        end
        if (w1 >= TO) begin
            push_halt(1'b0, 1'b1);
            halted = 1'b1;
            return;
        end
        e = '0; e.state = 3'd0; e.ins_req = 1'b1; e.ir_set = 1'b1;
        push_step(1'b1, rb(), rb(), r7(), e);
        e = '0; e.state = 3'd1; e.imm = im;
        push_step(rb(), rb(), rb(), op, e);
        if (k == K_ILL) begin
            push_halt(1'b1, 1'b0);
            halted = 1'b1;
            return;
        end
        e = '0; e.state = 3'd2; e.imm = im;
        if (k == K_BR) begin
            e.pc_set = 1'b1;
            e.pc_sel = tk ? 2'b01 : 2'b00;
        end
        push_step(rb(), rb(), (k == K_BR) ? tk : rb(), r7(), e);
        if (k == K_LD || k == K_ST) begin
            for (int i = 0; i < w2 && i < TO; i++) begin
                e = '0; e.state = 3'd3; e.imm = 1'b1; e.dreq = 1'b1; e.dwe = (k == K_ST);
                push_step(rb(), 1'b0, rb(), r7(), e);
            end
            if (w2 >= TO) begin
                push_halt(1'b0, 1'b1);
                halted = 1'b1;
                return;
            end
            e = '0; e.state = 3'd3; e.imm = 1'b1; e.dreq = 1'b1; e.dwe = (k == K_ST);
            e.pc_set = (k == K_ST);
            push_step(rb(), 1'b1, rb(), r7(), e);
        end
        if (k != K_BR && k != K_ST) begin
            e = '0; e.state = 3'd4; e.imm = im; e.gpr = 1'b1; e.pc_set = 1'b1;
            e.pc_sel = (k == K_JAL) ? 2'b01 : ((k == K_JALR) ? 2'b10 : 2'b00);
            push_step(rb(), rb(), rb(), r7(), e);
        end
    endtask

    // Tasks start and end 1 time unit after a rising edge.
    task automatic run_trace(input string name);
        step_t s;
        obs_t  got;
        int    idx;
        idx = 0;
        while (trace.size() > 0) begin
            s = trace.pop_front();
            ins_rdy = s.ins_rdy;
            d_rdy   = s.d_rdy;
            taken   = s.taken;
            opc     = s.opc;
            #3;
            got = sample_obs();
            vectors++;
            if (got !== s.exp) begin
                miscompares++;
                $display("FAIL %s step=%0d got=%h expected=%h", name, idx, got, s.exp);
            end
`ifdef CONTROL_UNIT_RETIRE_CNT_EN
            vectors++;
            if (retired !== exp_retired) begin
                miscompares++;
                $display("FAIL %s_retired step=%0d got=%0d expected=%0d", name, idx, retired, exp_retired);
            end
`endif
            if (s.exp.pc_set) exp_retired = exp_retired + 32'd1;
            idx++;
            @(posedge clk); #1;
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1; ins_rdy = 1'b0; d_rdy = 1'b0; taken = 1'b0; opc = 7'd0;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_retired = 32'd0;
    endtask

    task automatic test_reset();
        obs_t got;
        obs_t e;
        rst = 1'b1; ins_rdy = 1'b1; d_rdy = 1'b1; taken = 1'b1; opc = O_OP;
        #3;
        got = sample_obs();
        e   = '0;
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL reset_state got=%h expected=%h", got, e);
        end
`ifdef CONTROL_UNIT_RETIRE_CNT_EN
        vectors++;
        if (retired !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_retired got=%0d expected=0", retired);
        end
`endif
        @(posedge clk); #1;
        rst = 1'b0; ins_rdy = 1'b0;
        #3;
        vectors++;
        if (state !== 3'd0 || ins_req !== 1'b1 || ir_set !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset_fetch got state=%0d ins_req=%b ir_set=%b expected 0/1/0",
                     state, ins_req, ir_set);
        end
        @(posedge clk); #1;
        apply_reset();
    endtask

    task automatic test_directed();
        logic h;
        build_trace(O_OPIMM,  1'b0, 0, 0, h); run_trace("opimm");
        build_trace(O_BRANCH, 1'b1, 0, 0, h); run_trace("branch_taken");
        build_trace(O_BRANCH, 1'b0, 2, 0, h); run_trace("branch_not_taken");
        build_trace(O_LOAD,   1'b0, 0, 3, h); run_trace("load_wait3");
        build_trace(O_STORE,  1'b0, 0, 3, h); run_trace("store_wait3");
        build_trace(O_JAL,    1'b0, 1, 0, h); run_trace("jal");
        build_trace(O_JALR,   1'b0, 0, 0, h); run_trace("jalr");
        build_trace(O_LUI,    1'b0, 0, 0, h); run_trace("lui");
        build_trace(O_SYSTEM, 1'b0, 0, 0, h); run_trace("illegal_halt");
        apply_reset();
        build_trace(O_OP,     1'b0, 0, 0, h); run_trace("after_illegal");
    endtask

    task automatic test_timeout();
        logic h;
        build_trace(O_OP,    1'b0, TO - 1, 0, h);      run_trace("ins_ready_last_cycle");
        build_trace(O_LOAD,  1'b0, 0, TO - 1, h);      run_trace("data_ready_last_cycle");
        build_trace(O_OP,    1'b0, TO, 0, h);          run_trace("ins_timeout");
        apply_reset();
        build_trace(O_STORE, 1'b0, 0, TO, h);          run_trace("data_timeout");
        apply_reset();
    endtask

    task automatic test_reset_mid();
        logic h;
        ins_rdy = 1'b1; opc = O_STORE;  @(posedge clk); #1;
        ins_rdy = 1'b0;                 @(posedge clk); #1;
        opc = 7'd0;                     @(posedge clk); #1;
        d_rdy = 1'b0;                   #3;
        vectors++;
        if (state !== 3'd3 || dreq !== 1'b1 || dwe !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_in_memory got state=%0d dreq=%b dwe=%b expected 3/1/1", state, dreq, dwe);
        end
        @(posedge clk); #1;
        rst = 1'b1; d_rdy = 1'b1; ins_rdy = 1'b1;
        #3;
        vectors++;
        if ({pc_set, gpr, ir_set, ins_req, dreq, dwe, imm, pc_sel} !== 9'd0 || state !== 3'd3) begin
            miscompares++;
            $display("FAIL mid_reset_cycle got state=%0d strobes=%b expected state 3, strobes 0",
                     state, {pc_set, gpr, ir_set, ins_req, dreq, dwe, imm, pc_sel});
        end
        @(posedge clk); #1;
        rst = 1'b0; d_rdy = 1'b0; ins_rdy = 1'b0;
        exp_retired = 32'd0;
        build_trace(O_AUIPC, 1'b0, 1, 0, h);
        run_trace("restart_after_mid_reset");
    endtask

    task automatic test_random();
        logic [6:0] ops [0:8];
        logic [6:0] bad [0:3];
        logic [6:0] op;
        logic       h;
        int         w1, w2;
        ops = '{O_LOAD, O_STORE, O_OPIMM, O_OP, O_LUI, O_AUIPC, O_JAL, O_JALR, O_BRANCH};
        bad = '{O_SYSTEM, 7'b0001111, 7'b0000000, 7'b1111111};
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 15) == 0) op = bad[$urandom_range(0, 3)];
            else                            op = ops[$urandom_range(0, 8)];
            w1 = ($urandom_range(0, 9) == 0) ? TO - 1 : int'($urandom_range(0, 3));
            w2 = ($urandom_range(0, 9) == 0) ? TO - 1 : int'($urandom_range(0, 3));
            if ($urandom_range(0, 39) == 0) w1 = TO;
            build_trace(op, rb(), w1, w2, h);
            run_trace("random");
            if (h) apply_reset();
        end
    endtask

`ifdef CONTROL_UNIT_RETIRE_CNT_EN
    task automatic test_retire();
        logic h;
        apply_reset();
        build_trace(O_OP,     1'b0, 0, 0, h); run_trace("retire_op");
        build_trace(O_BRANCH, 1'b1, 0, 0, h); run_trace("retire_br");
        build_trace(O_STORE,  1'b0, 0, 1, h); run_trace("retire_st");
        #3;
        vectors++;
        if (retired !== 32'd3) begin
            miscompares++;
            $display("FAIL retire_three got=%0d expected=3", retired);
        end
        @(posedge clk); #1;
        apply_reset();
        #3;
        vectors++;
        if (retired !== 32'd0) begin
            miscompares++;
            $display("FAIL retire_reset got=%0d expected=0", retired);
        end
        @(posedge clk); #1;
        apply_reset();
    endtask
`endif

    initial begin
        rst = 1'b1; ins_rdy = 1'b0; d_rdy = 1'b0; taken = 1'b0; opc = 7'd0;
        @(posedge clk); #1;
        test_reset();
        test_directed();
        test_timeout();
        test_reset_mid();
        test_random();
`ifdef CONTROL_UNIT_RETIRE_CNT_EN
        test_retire();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 16, maximum wait cycles for a memory ready before fault (range 1..255).
REQ-002 SHALL have port: control_unit_clock_in  in  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: control_unit_reset_in  in  1  synchronous, active-high reset.
REQ-004 SHALL have port: control_unit_opcode_in  in  7  IR[6:0] from datapath.
REQ-005 SHALL have port: control_unit_ins_mem_ready_in  in  1  instruction word valid.
REQ-006 SHALL have port: control_unit_data_mem_ready_in  in  1  data access complete.
REQ-007 SHALL have port: control_unit_branch_taken_in  in  1  branch compare result.
REQ-008 SHALL have ports (all out): control_unit_pc_set_out 1, control_unit_ir_set_out 1, control_unit_pc_mux_sel_out 2 (00 PC+4, 01 PC+offset, 10 new value), control_unit_imm_mux_sel_out 1, control_unit_ins_mem_req_out 1, control_unit_data_mem_req_out 1, control_unit_data_mem_we_out 1, control_unit_gpr_set_rd_out 1.
REQ-009 SHALL have ports (all out): control_unit_illegal_out 1, control_unit_fault_out 1, control_unit_state_out 3.

Function
REQ-010 SHALL implement states FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, HALT=5; state_out is the state register.
REQ-011 FETCH: ins_mem_req=1; on ins_mem_ready, ir_set=1 same cycle (Mealy) and next state DECODE; else stay.
REQ-012 DECODE: latch opcode class; LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011 legal; any other opcode -> HALT with illegal_out=1; legal -> EXECUTE.
REQ-013 EXECUTE: BRANCH -> pc_set=1, pc_mux_sel=01 if branch_taken else 00, next FETCH; LOAD/STORE -> MEMORY; all others -> WRITEBACK.
REQ-014 MEMORY: data_mem_req=1, data_mem_we=1 only for STORE; on data_mem_ready: LOAD -> WRITEBACK; STORE -> pc_set=1, pc_mux_sel=00, next FETCH.
REQ-015 WRITEBACK: gpr_set_rd=1 and pc_set=1 in the same single cycle; pc_mux_sel=01 for JAL, 10 for JALR, 00 otherwise; next FETCH.
REQ-016 imm_mux_sel SHALL be 1 from DECODE through WRITEBACK for OP-IMM, LOAD, STORE, LUI, AUIPC, JALR; 0 otherwise and 0 in FETCH/HALT.
REQ-017 pc_mux_sel SHALL be 00 in every cycle where pc_set=0.
REQ-018 pc_set SHALL assert exactly once per legal instruction; ir_set exactly once per fetch.
REQ-019 An 8-bit wait counter SHALL count consecutive cycles in FETCH/MEMORY without ready, clear on ready or state change; when it reaches TIMEOUT_CYCLES -> HALT with fault_out=1.
REQ-020 Ready arriving in the same cycle the counter reaches TIMEOUT_CYCLES SHALL win (normal transition, no fault).
REQ-021 HALT: all strobes and requests 0; remain until reset; illegal_out/fault_out sticky.
REQ-022 Latency: ALU op 4 cycles, branch 3, store 4, load 5, each plus memory wait cycles.

Reset
REQ-023 While reset_in=1 all strobe/request outputs SHALL be 0 regardless of state.
REQ-024 On reset: state FETCH, wait counter 0, class register 0, illegal_out=0, fault_out=0.
REQ-025 Reset asserted mid-instruction SHALL abort it with no pc_set/gpr_set_rd in that cycle; fetch restarts the cycle after deassertion.

Configuration
REQ-026 With CONTROL_UNIT_RETIRE_CNT_EN defined: extra output control_unit_retired_count_out [31:0], reset 0, +1 on each pc_set cycle, wraps 0xFFFFFFFF->0; without it the port and counter SHALL not exist.

Structure
REQ-027 Opcode constants, state encoding, class encoding and pc_mux select codes SHALL live in shared package core101_pkg.
REQ-028 Opcode-to-class/imm_sel/illegal decode SHALL be a combinational sub-module opcode_decoder.

Verification
REQ-029 Opcode 0010011, ins_ready immediate, data_ready unused -> states 0,1,2,4,0; gpr_set_rd and pc_set together in cycle 4, pc_mux_sel=00, imm_sel=1.
REQ-030 BRANCH 1100011 with branch_taken=1 -> pc_set in EXECUTE with pc_mux_sel=01, no gpr_set_rd; with taken=0 -> sel=00.
REQ-031 LOAD with data_ready delayed 3 cycles -> data_mem_req high 4 cycles, we=0, then WRITEBACK; STORE same -> we=1, pc_set on ready cycle, no WRITEBACK.
REQ-032 Opcode 1110011 -> HALT after DECODE, illegal_out=1 sticky, no pc_set; reset -> FETCH, illegal_out=0.
REQ-033 ins_ready held 0 with TIMEOUT_CYCLES=16 -> HALT, fault_out=1 after 16 wait cycles; ready on cycle 16 -> DECODE, no fault.
REQ-034 Reset pulsed in MEMORY -> no strobes that cycle, FETCH next; with CONTROL_UNIT_RETIRE_CNT_EN, 3 instructions -> count 3, reset -> 0.
